// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI message assembler.
//   - status nibble constants
//   - MIDI_MSG field positions and a packing helper
//   - serial receiver state encoding
package midi_pkg;

  localparam logic [3:0] NOTE_OFF   = 4'h8;
  localparam logic [3:0] NOTE_ON    = 4'h9;
  localparam logic [3:0] PROG_CHG   = 4'hC;
  localparam logic [3:0] CHAN_PRESS = 4'hD;
  localparam logic [3:0] SYS        = 4'hF;

  // MIDI_MSG layout: [23:16] status, [15:8] data1, [7:0] data2
  localparam int MSG_STATUS_LSB = 16;
  localparam int MSG_D1_LSB     = 8;
  localparam int MSG_D2_LSB     = 0;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [23:0] pack_msg(input logic [7:0] s, input logic [7:0] d1,
                                           input logic [7:0] d2);
    logic [23:0] m;
    m = '0;
    m[MSG_STATUS_LSB +: 8] = s;
    m[MSG_D1_LSB +: 8]     = d1;
    m[MSG_D2_LSB +: 8]     = d2;
    return m;
  endfunction

  // Program change and channel pressure carry a single data byte.
  function automatic logic is_one_data(input logic [7:0] s);
    return (s[7:4] == PROG_CHG) || (s[7:4] == CHAN_PRESS);
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial receiver for the MIDI IN line.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   serial_in     raw line, asynchronous, idle high
//   data_byte     last good byte (held)
//   byte_valid    1-cycle pulse, good stop bit seen
//   frame_err     1-cycle pulse, stop bit sampled low (byte dropped)
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial_in,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1, sync2, rx_prev;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data_byte  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync1      <= serial_in;
      sync2      <= sync1;
      rx_prev    <= sync2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          // Falling edge on the synchronised line marks a start bit.
          if (rx_prev && !sync2) begin
            state   <= RX_START;
            cnt     <= '0;
            bit_idx <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF_END) begin
            cnt   <= '0;
            // Line back high at mid-start: treat as a glitch, no error.
            state <= sync2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt == BIT_END) begin
            cnt     <= '0;
            shreg   <= {sync2, shreg[7:1]};  // LSB first
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (sync2) begin
              data_byte  <= shreg;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/midi_msg_assembler.sv
// Assembles MIDI channel-voice messages from the serial MIDI IN stream.
// Handles running status, ignores real-time bytes, drops system messages
// and orphan data bytes.
// Optional build macro: MIDI_NOTEOFF_CONV_EN -- note-on with velocity 0 is
// emitted as note-off (running status keeps the note-on status).
// Ports:
//   CLK, RST_N    clock, async active-low reset
//   MIDI_IN       raw serial line, idle high
//   MIDI_MSG      {status, data1, data2}, held until next message
//   MIDI_MSG_RDY  1-cycle pulse when MIDI_MSG is updated
//   RX_ERR        1-cycle pulse on a framing error
module midi_msg_assembler
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 31250
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        MIDI_IN,
  output logic [23:0] MIDI_MSG,
  output logic        MIDI_MSG_RDY,
  output logic        RX_ERR
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] run_status;  // bit7 clear means no running status
  logic [7:0] d1;
  logic       have_d1;
  logic [7:0] out_status;

  midi_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (CLK),
    .rst_n     (RST_N),
    .serial_in (MIDI_IN),
    .data_byte (rx_data),
    .byte_valid(rx_valid),
    .frame_err (RX_ERR)
  );

  // Status as emitted on a 2-data completion; only differs from the
  // running status when note-off conversion is built in.
  always_comb begin
    out_status = run_status;
`ifdef MIDI_NOTEOFF_CONV_EN
    if (run_status[7:4] == NOTE_ON && rx_data == 8'h00)
      out_status = {NOTE_OFF, run_status[3:0]};
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      run_status   <= '0;
      d1           <= '0;
      have_d1      <= 1'b0;
      MIDI_MSG     <= '0;
      MIDI_MSG_RDY <= 1'b0;
    end else begin
      MIDI_MSG_RDY <= 1'b0;
      if (rx_valid) begin
        if (rx_data[7:4] == SYS) begin
          // 0xF8-0xFF real-time: no effect. 0xF0-0xF7: drop running status.
          if (!rx_data[3]) begin
            run_status <= '0;
            have_d1    <= 1'b0;
          end
        end else if (rx_data[7]) begin
          // New channel status abandons any partial message.
          run_status <= rx_data;
          have_d1    <= 1'b0;
        end else if (run_status[7]) begin
          if (is_one_data(run_status)) begin
            MIDI_MSG     <= pack_msg(run_status, rx_data, 8'h00);
            MIDI_MSG_RDY <= 1'b1;
          end else if (!have_d1) begin
            d1      <= rx_data;
            have_d1 <= 1'b1;
          end else begin
            MIDI_MSG     <= pack_msg(out_status, d1, rx_data);
            MIDI_MSG_RDY <= 1'b1;
            have_d1      <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_assembler.sv
// Scoreboard bench for midi_msg_assembler at CLKS_PER_BIT = 10.
module tb_midi_msg_assembler;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        MIDI_IN = 1'b1;
  logic [23:0] MIDI_MSG;
  logic        MIDI_MSG_RDY;
  logic        RX_ERR;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_cnt = 0;
  int exp_rdy = 0;
  int err_cnt = 0;
  int bv_cnt = 0;
  int rdy_cyc = 0;
  int last_start = 0;
  logic [23:0] exp_q[$];

  midi_msg_assembler #(.CLK_HZ(312500), .BAUD(31250)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .MIDI_IN     (MIDI_IN),
    .MIDI_MSG    (MIDI_MSG),
    .MIDI_MSG_RDY(MIDI_MSG_RDY),
    .RX_ERR      (RX_ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every message pulse.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (MIDI_MSG_RDY) begin
        rdy_cnt++;
        rdy_cyc = cyc;
        if (exp_q.size() == 0) chk("rdy_unexpected", 32'(MIDI_MSG_RDY), 32'd0);
        else chk("msg", 32'(MIDI_MSG), 32'(exp_q.pop_front()));
      end
      if (RX_ERR) err_cnt++;
      if (dut.u_rx.byte_valid) bv_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic drive_bit(input logic v);
    MIDI_IN = v;
    repeat (10) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
    last_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_lvl);
    MIDI_IN = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
  endtask

  task automatic expect_msg(input logic [23:0] m);
    exp_q.push_back(m);
    exp_rdy++;
  endtask

  task automatic settle_check(input string tag, input int errs);
    repeat (30) @(posedge CLK);
    #1;
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_rdys"}, 32'(rdy_cnt), 32'(exp_rdy));
    chk({tag, "_errs"}, 32'(err_cnt), 32'(errs));
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    int lat;
    int bv0;
    logic [23:0] v0msg;
    // reset state
    repeat (2) @(negedge CLK);
    chk("rst_msg", 32'(MIDI_MSG), 32'd0);
    chk("rst_rdy", 32'(MIDI_MSG_RDY), 32'd0);
    chk("rst_err", 32'(RX_ERR), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (5) @(posedge CLK); #1;

    // 1: basic note-on, with latency window from the third frame's start edge
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    expect_msg(24'h903C64);
    send_byte(8'h64, 1'b1);
    lat = rdy_cyc - last_start;
    chk("lat_window", 32'(lat >= 96 && lat <= 102), 32'd1);
    settle_check("t1", 0);

    // 2: running status
    send_byte(8'h91, 1'b1);
    send_byte(8'h40, 1'b1);
    expect_msg(24'h914050);
    send_byte(8'h50, 1'b1);
    send_byte(8'h43, 1'b1);
    expect_msg(24'h914350);
    send_byte(8'h50, 1'b1);
    settle_check("t2", 0);
    chk("hold", 32'(MIDI_MSG), 32'h914350);

    // 3: real-time byte mid-message, then program change
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hF8, 1'b1);
    expect_msg(24'h903C64);
    send_byte(8'h64, 1'b1);
    send_byte(8'hC2, 1'b1);
    expect_msg(24'hC20500);
    send_byte(8'h05, 1'b1);
    settle_check("t3", 0);

    // 4: framing error on the status byte, orphan data, then a clean note-off
    do_reset();
    send_byte(8'h90, 1'b0);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h64, 1'b1);
    settle_check("t4a", 1);
    send_byte(8'h80, 1'b1);
    send_byte(8'h3C, 1'b1);
    expect_msg(24'h803C00);
    send_byte(8'h00, 1'b1);
    settle_check("t4b", 1);

    // 5: system exclusive and orphan data produce nothing
    send_byte(8'hF0, 1'b1);
    send_byte(8'h7E, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hF7, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h40, 1'b1);
    settle_check("t5a", 1);
    // reset during the second data bit of the completing byte
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    MIDI_IN = 1'b0;
    repeat (5) @(posedge CLK); #1;
    RST_N = 1'b0;
    @(negedge CLK);
    chk("midrst_msg", 32'(MIDI_MSG), 32'd0);
    chk("midrst_rdy", 32'(MIDI_MSG_RDY), 32'd0);
    repeat (3) @(posedge CLK); #1;
    MIDI_IN = 1'b1;
    RST_N = 1'b1;
    repeat (150) @(posedge CLK); #1;
    chk("postrst_msg", 32'(MIDI_MSG), 32'd0);
    settle_check("t5b", 1);

    // 6: velocity-0 note-on, then running status keeps note-on
`ifdef MIDI_NOTEOFF_CONV_EN
    v0msg = 24'h853C00;
`else
    v0msg = 24'h953C00;
`endif
    send_byte(8'h95, 1'b1);
    send_byte(8'h3C, 1'b1);
    expect_msg(v0msg);
    send_byte(8'h00, 1'b1);
    send_byte(8'h3C, 1'b1);
    expect_msg(24'h953C40);
    send_byte(8'h40, 1'b1);
    settle_check("t6", 1);

    // 0.3-bit low glitch on an idle line
    bv0 = bv_cnt;
    MIDI_IN = 1'b0;
    repeat (3) @(posedge CLK); #1;
    MIDI_IN = 1'b1;
    repeat (150) @(posedge CLK); #1;
    chk("glitch_bytes", 32'(bv_cnt), 32'(bv0));
    settle_check("glitch", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/midi_msg_assembler.md
Name: midi_msg_assembler

Overview:
- Receives the serial MIDI IN stream (31250 baud, 8N1, idle high) and assembles complete 3-byte channel-voice messages.
- Drives the 24-bit MIDI_MSG / MIDI_MSG_RDY interface consumed by the polyphonic wave generator chain.
- Handles running status, real-time bytes, system messages and framing errors.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 31250, serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 1600 at defaults).

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- MIDI_IN  input  1  raw serial MIDI line, asynchronous to CLK, idle high.
- MIDI_MSG  output  24  assembled message: [23:16] status, [15:8] data1, [7:0] data2.
- MIDI_MSG_RDY  output  1  one-cycle pulse; MIDI_MSG is valid in the same cycle and holds until the next pulse.
- RX_ERR  output  1  one-cycle pulse on a framing error (stop bit sampled low).

Behaviour:
- Reset: asynchronous, active-low. MIDI_MSG=0, MIDI_MSG_RDY=0, RX_ERR=0. Running status cleared, data count 0, receiver in IDLE, synchroniser flops set to 1.
- Input sync: 2-flop synchroniser on MIDI_IN. All decisions use the synchronised signal.
- Receiver FSM:
  - IDLE: a 1->0 edge goes to START and clears the bit counter.
  - START: at CLKS_PER_BIT/2, re-sample. Low: go to DATA. High: glitch, return to IDLE with no error.
  - DATA: sample every CLKS_PER_BIT, 8 bits, LSB first.
  - STOP: sample one CLKS_PER_BIT later. High: byte_valid pulses 1 cycle. Low: RX_ERR pulses, byte discarded, parser state unchanged. Then return to IDLE.
  - The receiver only re-arms in IDLE, so a new start edge during STOP is ignored.
- Parser, applied per valid byte:
  - 0xF8-0xFF (real-time): ignored. Running status and partially collected data are untouched.
  - 0xF0-0xF7 (system): running status cleared, data count 0. Data bytes are then discarded until the next channel status.
  - 0x80-0xEF (channel status): stored as running status, data count 0. Expected length is 1 for 0xCn/0xDn, 2 otherwise.
  - Data byte (bit7=0) with no running status: discarded.
  - Data byte with running status: stored as data1 or data2.
- Message completion:
  - When the expected count is reached, MIDI_MSG={status,d1,d2} with d2=0x00 for 1-data messages.
  - MIDI_MSG_RDY is high in the cycle after byte_valid, i.e. 2 cycles after the stop-bit sample cycle.
  - Data count returns to 0 and status is retained (running status).
- A new status byte arriving mid-message abandons the partial message; nothing is emitted for it.
- Reset asserted mid-byte or mid-message drops all partial state; no pulse is emitted after reset release.

Optional Feature:
- Macro: MIDI_NOTEOFF_CONV_EN.
- Defined: a completed 0x9n kk 0x00 is emitted as 0x8n kk 0x00. Running status stays 0x9n, so a following data pair still decodes as note-on.
- Undefined: the message is emitted unmodified.

Decomposition:
- Shared package midi_pkg holds:
  - status constants: NOTE_OFF=4'h8, NOTE_ON=4'h9, PROG_CHG=4'hC, CHAN_PRESS=4'hD, SYS=4'hF;
  - field positions of MIDI_MSG (status/data1/data2 slices);
  - the receiver state enum.
- Sub-module midi_uart_rx (synchroniser plus receiver FSM) outputs byte[7:0], byte_valid and frame_err. The parser lives in midi_msg_assembler.

Test Plan (simulate with CLK_HZ=312500 so CLKS_PER_BIT=10):
1. Bytes 0x90,0x3C,0x64 -> one MIDI_MSG_RDY pulse, MIDI_MSG=24'h903C64, 2 cycles after the 3rd stop-bit sample; RX_ERR stays 0.
2. Running status: 0x91,0x40,0x50,0x43,0x50 -> two pulses, 24'h914050 then 24'h914350.
3. Interleaved real-time plus program change: 0x90,0x3C,0xF8,0x64 then 0xC2,0x05 -> 24'h903C64 then 24'hC20500; the 0xF8 produces no effect.
4. Framing error: 0x90 sent with a low stop bit, then 0x3C,0x64 -> RX_ERR pulse; no message (no running status); then a valid 0x80,0x3C,0x00 -> 24'h803C00.
5. System/orphan data: 0xF0,0x7E,0x01,0xF7,0x3C,0x40 -> no pulses. Reset pulse during the second data bit of 0x64 in a 0x90,0x3C,0x64 sequence -> outputs 0 and no pulse after release.
6. Velocity 0: 0x95,0x3C,0x00 -> 24'h853C00 with MIDI_NOTEOFF_CONV_EN defined, 24'h953C00 without. A 0.3-bit-wide low glitch on an idle line -> no byte and no RX_ERR.
